// File: rtl/vec_alu_stream_ctrl_pkg.sv
// Shared types and constants for the vector ALU stream sequencer.
// Holds the datapath geometry, the opcode encodings and the FSM state type.
package vec_ctrl_pkg;

  localparam int WIDTH_V    = 128;
  localparam int BITS_INDEX = 8;
  localparam int ADDR_W     = 10;
  localparam int LEN_W      = 8;
  localparam int NL         = WIDTH_V / BITS_INDEX;
  localparam int FLAGS_W    = NL * 4;

  // The sequencer treats opcodes as opaque; these encodings are for users of the ALU.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_DOT  = 3'b011;
  localparam logic [2:0] OP_ADDS = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WR,
    FIN
  } state_t;

  // Element address; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/vec_alu_stream_ctrl_if.sv
// Command, memory and ALU signal bundle of the vector ALU stream sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface vec_alu_stream_ctrl_if;
  import vec_ctrl_pkg::*;

  logic                  start;
  logic [2:0]            cmd_opcode;
  logic [BITS_INDEX-1:0] cmd_scalar;
  logic [ADDR_W-1:0]     cmd_a_base;
  logic [ADDR_W-1:0]     cmd_b_base;
  logic [ADDR_W-1:0]     cmd_d_base;
  logic [LEN_W-1:0]      cmd_len;
  logic                  busy;
  logic                  done;
  logic [FLAGS_W-1:0]    flags_acc;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rd_en;
  logic [WIDTH_V-1:0]    mem_rdata;
  logic                  mem_wr_en;
  logic [WIDTH_V-1:0]    mem_wdata;
  logic [WIDTH_V-1:0]    alu_a;
  logic [WIDTH_V-1:0]    alu_b;
  logic [BITS_INDEX-1:0] alu_c;
  logic [2:0]            alu_opcode;
  logic [WIDTH_V-1:0]    alu_result;
  logic [FLAGS_W-1:0]    alu_flags;

  modport master (
    input  start, cmd_opcode, cmd_scalar, cmd_a_base, cmd_b_base, cmd_d_base, cmd_len,
    input  mem_rdata, alu_result, alu_flags,
    output busy, done, flags_acc, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output alu_a, alu_b, alu_c, alu_opcode
  );

  modport slave (
    output start, cmd_opcode, cmd_scalar, cmd_a_base, cmd_b_base, cmd_d_base, cmd_len,
    output mem_rdata, alu_result, alu_flags,
    input  busy, done, flags_acc, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  alu_a, alu_b, alu_c, alu_opcode
  );

endinterface

// File: rtl/vec_alu_stream_ctrl.sv
// Streams one vector ALU operation over LEN memory words: read A, read B, execute, write DST.
// Four cycles per element through the shared single-port memory; flags are OR-accumulated.
module vec_alu_stream_ctrl
  import vec_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  vec_alu_stream_ctrl_if.master bus
);

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_W-1:0]      r_idx;
  logic [LEN_W-1:0]      r_len;
  logic [ADDR_W-1:0]     r_a_base;
  logic [ADDR_W-1:0]     r_b_base;
  logic [ADDR_W-1:0]     r_d_base;
  logic [2:0]            r_opcode;
  logic [BITS_INDEX-1:0] r_scalar;
  logic [WIDTH_V-1:0]    r_alu_a;
  logic [WIDTH_V-1:0]    r_alu_b;
  logic [FLAGS_W-1:0]    r_flags_acc;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [ADDR_W-1:0]     w_addr;
  logic [WIDTH_V-1:0]    w_wdata;
  logic                  w_busy;
  logic                  w_done;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_idx == (r_len - LEN_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.cmd_len == '0) ? FIN : RD_A;
        end
      end
      RD_A: begin
        w_rd_en      = 1'b1;
        w_addr       = elem_addr(r_a_base, r_idx);
        w_busy       = 1'b1;
        w_state_next = RD_B;
      end
      RD_B: begin
        w_rd_en      = 1'b1;
        w_addr       = elem_addr(r_b_base, r_idx);
        w_busy       = 1'b1;
        w_state_next = EXEC;
      end
      EXEC: begin
        w_busy       = 1'b1;
        w_state_next = WR;
      end
      WR: begin
        w_wr_en      = 1'b1;
        w_addr       = elem_addr(r_d_base, r_idx);
        w_wdata      = bus.alu_result;
        w_busy       = 1'b1;
        w_state_next = w_last ? FIN : RD_A;
      end
      FIN: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Command fields are captured once per run; a start seen outside IDLE never reaches here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_a_base    <= '0;
      r_b_base    <= '0;
      r_d_base    <= '0;
      r_opcode    <= '0;
      r_scalar    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_flags_acc <= '0;
    end else begin
      if (w_accept) begin
        r_idx       <= '0;
        r_len       <= bus.cmd_len;
        r_a_base    <= bus.cmd_a_base;
        r_b_base    <= bus.cmd_b_base;
        r_d_base    <= bus.cmd_d_base;
        r_opcode    <= bus.cmd_opcode;
        r_scalar    <= bus.cmd_scalar;
        r_flags_acc <= '0;
      end
      if (r_state == RD_B) begin
        r_alu_a <= bus.mem_rdata;
      end
      if (r_state == EXEC) begin
        r_alu_b <= bus.mem_rdata;
      end
      if (r_state == WR) begin
        r_flags_acc <= r_flags_acc | bus.alu_flags;
        if (!w_last) begin
          r_idx <= r_idx + LEN_W'(1);
        end
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.flags_acc  = r_flags_acc;
  assign bus.mem_addr   = w_addr;
  assign bus.mem_rd_en  = w_rd_en;
  assign bus.mem_wr_en  = w_wr_en;
  assign bus.mem_wdata  = w_wdata;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_c      = r_scalar;
  assign bus.alu_opcode = r_opcode;

endmodule

// File: tb/tb_vec_alu_stream_ctrl.sv
// Bench for vec_alu_stream_ctrl: 1-cycle memory model, reference lane ALU, and a write scoreboard
// filled when each command is issued and drained as the sequencer writes results back.
module tb_vec_alu_stream_ctrl;
  import vec_ctrl_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [WIDTH_V-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_alu_stream_ctrl_if ifc();

  vec_alu_stream_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [WIDTH_V-1:0] mem [0:(1<<ADDR_W)-1];
  logic               pre_we = 1'b0;
  logic [ADDR_W-1:0]  pre_addr = '0;
  logic [WIDTH_V-1:0] pre_data = '0;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0;
  logic [ADDR_W-1:0] rd_log[$];
  wr_t               exp_q[$];
  logic [FLAGS_W-1:0] exp_flags;
  logic [FLAGS_W-1:0] zmask;

  // Lane flags: bit0 zero, bit1 negative, bit2 carry/borrow, bit3 reserved.
  function automatic logic [FLAGS_W+WIDTH_V-1:0] ref_alu(input logic [2:0] op,
      input logic [WIDTH_V-1:0] a, input logic [WIDTH_V-1:0] b, input logic [BITS_INDEX-1:0] c);
    logic [WIDTH_V-1:0] r;
    logic [FLAGS_W-1:0] f;
    logic [8:0] s;
    logic [7:0] x, y;
    r = '0;
    f = '0;
    for (int k = 0; k < NL; k++) begin
      x = a[k*8 +: 8];
      y = b[k*8 +: 8];
      case (op)
        OP_ADD:  s = {1'b0, x} + {1'b0, y};
        OP_SUB:  s = {1'b0, x} - {1'b0, y};
        OP_AND:  s = {1'b0, x & y};
        OP_DOT:  s = {1'b0, x * y};
        OP_ADDS: s = {1'b0, x} + {1'b0, c};
        default: s = {1'b0, x};
      endcase
      r[k*8 +: 8] = s[7:0];
      f[k*4 +: 4] = {1'b0, s[8], s[7], s[7:0] == 8'd0};
    end
    return {f, r};
  endfunction

  always_comb {ifc.alu_flags, ifc.alu_result} = ref_alu(ifc.alu_opcode, ifc.alu_a, ifc.alu_b, ifc.alu_c);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.mem_rd_en) ifc.mem_rdata <= mem[ifc.mem_addr];
    if (ifc.mem_wr_en) mem[ifc.mem_addr] <= ifc.mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-side scoreboard plus per-cycle port rules.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_exclusive", 256'(ifc.mem_rd_en & ifc.mem_wr_en), 256'(0));
      chk("idle_addr_zero", (ifc.mem_rd_en | ifc.mem_wr_en) ? 256'(0) : 256'(ifc.mem_addr), 256'(0));
      if (ifc.mem_rd_en) begin
        rd_cnt++;
        rd_log.push_back(ifc.mem_addr);
      end
      if (ifc.busy) busy_cnt++;
      if (ifc.done) done_cnt++;
      if (ifc.mem_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 256'(ifc.mem_addr), 256'(0) - 256'(1));
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 256'(ifc.mem_addr), 256'(e.addr));
          chk("wr_data", 256'(ifc.mem_wdata), 256'(e.data));
        end
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [WIDTH_V-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic fill(input logic [ADDR_W-1:0] base, input int n, input logic [7:0] seed);
    logic [WIDTH_V-1:0] w;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NL; k++) w[k*8 +: 8] = seed + 8'(i*16 + k*3);
      preload(ADDR_W'(base + ADDR_W'(i)), w);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [7:0] c, input logic [ADDR_W-1:0] a,
                          input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d, input int n);
    logic [FLAGS_W+WIDTH_V-1:0] r;
    wr_t e;
    exp_flags = '0;
    for (int i = 0; i < n; i++) begin
      r = ref_alu(op, mem[ADDR_W'(a + ADDR_W'(i))], mem[ADDR_W'(b + ADDR_W'(i))], c);
      e.addr = ADDR_W'(d + ADDR_W'(i));
      e.data = r[WIDTH_V-1:0];
      exp_q.push_back(e);
      exp_flags |= r[FLAGS_W+WIDTH_V-1:WIDTH_V];
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] c, input logic [ADDR_W-1:0] a,
                       input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d,
                       input logic [LEN_W-1:0] len, output int unsigned c0);
    ifc.cmd_opcode = op;
    ifc.cmd_scalar = c;
    ifc.cmd_a_base = a;
    ifc.cmd_b_base = b;
    ifc.cmd_d_base = d;
    ifc.cmd_len    = len;
    ifc.start      = 1'b1;
    @(negedge clk);
    ifc.start      = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int unsigned c0, output int unsigned edges);
    while (ifc.done !== 1'b1 && (cyc - c0) < 400) @(negedge clk);
    chk("done_seen", 256'(ifc.done), 256'(1));
    edges = cyc - c0 + 1;
  endtask

  initial begin
    int unsigned c0, edges;
    int saved_done;
    logic [ADDR_W-1:0] exp_rd [4];
    logic [7:0] lane;

    for (int k = 0; k < NL; k++) zmask[k*4 +: 4] = 4'b0001;
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.cmd_opcode = '0;
    ifc.cmd_scalar = '0;
    ifc.cmd_a_base = '0;
    ifc.cmd_b_base = '0;
    ifc.cmd_d_base = '0;
    ifc.cmd_len    = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 256'(ifc.busy), 256'(0));
    chk("rst_done", 256'(ifc.done), 256'(0));
    chk("rst_ports", {ifc.flags_acc, ifc.mem_addr, ifc.mem_rd_en, ifc.mem_wr_en, ifc.alu_c, ifc.alu_opcode}, 256'(0));
    chk("rst_operands", {ifc.alu_a, ifc.alu_b}, 256'(0));
    chk("rst_wdata", 256'(ifc.mem_wdata), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic add run, len 3
    for (int i = 0; i < 3; i++) begin
      preload(ADDR_W'(10'h010 + i), {NL{8'h01}});
      preload(ADDR_W'(10'h020 + i), {NL{8'h01}});
    end
    push_exp(OP_ADD, 8'h00, 10'h010, 10'h020, 10'h030, 3);
    issue(OP_ADD, 8'h00, 10'h010, 10'h020, 10'h030, 8'd3, c0);
    chk("t1_busy_run", 256'(ifc.busy), 256'(1));
    wait_done(c0, edges);
    $display("t1 add len=3 done after %0d cycles flags=%h", edges, ifc.flags_acc);
    chk("t1_latency", 256'(edges), 256'(13));
    chk("t1_busy_fin", 256'(ifc.busy), 256'(0));
    chk("t1_flags", 256'(ifc.flags_acc), 256'(exp_flags));
    chk("t1_zbits", 256'(ifc.flags_acc & zmask), 256'(0));
    @(negedge clk);
    chk("t1_sb_drained", 256'(exp_q.size()), 256'(0));
    for (int i = 0; i < 3; i++) chk("t1_dst", 256'(mem[ADDR_W'(10'h030 + i)]), 256'({NL{8'h02}}));

    // Zero length
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
    issue(OP_ADD, 8'h00, 10'h040, 10'h050, 10'h060, 8'd0, c0);
    wait_done(c0, edges);
    $display("t2 len=0 done after %0d cycles", edges);
    chk("t2_latency", 256'(edges), 256'(1));
    repeat (3) @(negedge clk);
    chk("t2_no_reads", 256'(rd_cnt), 256'(0));
    chk("t2_no_writes", 256'(wr_cnt), 256'(0));
    chk("t2_no_busy", 256'(busy_cnt), 256'(0));
    chk("t2_one_done", 256'(done_cnt), 256'(1));

    // Address wrap on A
    preload(10'h3FF, {NL{8'h11}});
    preload(10'h000, {NL{8'hF0}});
    preload(10'h100, {NL{8'h22}});
    preload(10'h101, {NL{8'h0F}});
    rd_log.delete();
    push_exp(OP_ADD, 8'h00, 10'h3FF, 10'h100, 10'h200, 2);
    issue(OP_ADD, 8'h00, 10'h3FF, 10'h100, 10'h200, 8'd2, c0);
    wait_done(c0, edges);
    $display("t3 wrap len=2 done after %0d cycles, %0d reads", edges, rd_log.size());
    chk("t3_latency", 256'(edges), 256'(9));
    chk("t3_read_count", 256'(rd_log.size()), 256'(4));
    exp_rd = '{10'h3FF, 10'h100, 10'h000, 10'h101};
    for (int i = 0; i < 4; i++)
      if (i < rd_log.size()) chk("t3_read_addr", 256'(rd_log[i]), 256'(exp_rd[i]));
    @(negedge clk);
    chk("t3_sb_drained", 256'(exp_q.size()), 256'(0));

    // Sticky flags with sub
    preload(10'h080, {NL{8'h05}});
    preload(10'h090, {NL{8'h05}});
    preload(10'h081, {NL{8'h03}});
    preload(10'h091, {NL{8'h07}});
    push_exp(OP_SUB, 8'h00, 10'h080, 10'h090, 10'h0A0, 2);
    issue(OP_SUB, 8'h00, 10'h080, 10'h090, 10'h0A0, 8'd2, c0);
    wait_done(c0, edges);
    $display("t4 sub len=2 done after %0d cycles flags=%h", edges, ifc.flags_acc);
    chk("t4_flags", 256'(ifc.flags_acc), 256'(exp_flags));
    chk("t4_zbits_all", 256'(ifc.flags_acc & zmask), 256'(zmask));
    repeat (5) @(negedge clk);
    chk("t4_flags_hold", 256'(ifc.flags_acc), 256'(exp_flags));

    // Start while busy is ignored
    fill(10'h0B0, 3, 8'h3C);
    fill(10'h0C0, 3, 8'hA7);
    push_exp(OP_AND, 8'h00, 10'h0B0, 10'h0C0, 10'h0D0, 3);
    issue(OP_AND, 8'h00, 10'h0B0, 10'h0C0, 10'h0D0, 8'd3, c0);
    chk("t5_flags_cleared", 256'(ifc.flags_acc), 256'(0));
    repeat (4) @(negedge clk);
    ifc.cmd_opcode = OP_DOT;
    ifc.cmd_len    = 8'd1;
    ifc.cmd_d_base = 10'h0E0;
    ifc.start      = 1'b1;
    @(negedge clk);
    ifc.start      = 1'b0;
    wait_done(c0, edges);
    $display("t5 and len=3 with stray start done after %0d cycles", edges);
    chk("t5_latency", 256'(edges), 256'(13));
    chk("t5_opcode_kept", 256'(ifc.alu_opcode), 256'(OP_AND));
    chk("t5_flags", 256'(ifc.flags_acc), 256'(exp_flags));
    @(negedge clk);
    chk("t5_sb_drained", 256'(exp_q.size()), 256'(0));

    // Reset during WR of element 1
    fill(10'h140, 4, 8'h21);
    fill(10'h150, 4, 8'h47);
    for (int i = 1; i < 4; i++) preload(ADDR_W'(10'h160 + i), {NL{8'hA5}});
    push_exp(OP_ADD, 8'h00, 10'h140, 10'h150, 10'h160, 1);
    saved_done = done_cnt;
    issue(OP_ADD, 8'h00, 10'h140, 10'h150, 10'h160, 8'd4, c0);
    while ((cyc - c0) < 6) @(negedge clk);
    @(posedge clk);
    #1;
    chk("t6_in_wr", 256'(ifc.mem_wr_en), 256'(1));
    rst = 1'b1;
    #1;
    $display("t6 reset asserted in WR of element 1");
    chk("t6_rst_wr_en", 256'(ifc.mem_wr_en), 256'(0));
    chk("t6_rst_busy", 256'(ifc.busy), 256'(0));
    chk("t6_rst_ports", {ifc.flags_acc, ifc.mem_addr, ifc.mem_rd_en, ifc.alu_opcode, ifc.done}, 256'(0));
    chk("t6_rst_operands", {ifc.alu_a, ifc.alu_b}, 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_no_done", 256'(done_cnt), 256'(saved_done));
    chk("t6_sb_drained", 256'(exp_q.size()), 256'(0));
    for (int i = 1; i < 4; i++) chk("t6_dst_untouched", 256'(mem[ADDR_W'(10'h160 + i)]), 256'({NL{8'hA5}}));

    // Fresh run after reset
    lane = 8'hF8;
    push_exp(OP_ADDS, lane, 10'h140, 10'h150, 10'h170, 2);
    issue(OP_ADDS, lane, 10'h140, 10'h150, 10'h170, 8'd2, c0);
    wait_done(c0, edges);
    $display("t6 post-reset adds len=2 done after %0d cycles flags=%h", edges, ifc.flags_acc);
    chk("t6_post_latency", 256'(edges), 256'(9));
    chk("t6_post_flags", 256'(ifc.flags_acc), 256'(exp_flags));
    chk("t6_post_scalar", 256'(ifc.alu_c), 256'(lane));
    @(negedge clk);
    chk("t6_post_sb_drained", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
